// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchronised input, 3-sample majority voting,
// optional parity, 1/2 stop bits, 1-deep valid/ready holding register with overrun pulse.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] S_LO  = CW'(M - 1);
  localparam logic [CW-1:0] S_MID = CW'(M);
  localparam logic [CW-1:0] S_HI  = CW'(M + 1);
  localparam logic [CW-1:0] S_END = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS == 2);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [1:0]           samp, samp_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 maj, decide, bit_end, complete;

  assign maj     = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign decide  = b_tick && (cnt == S_HI);
  assign bit_end = b_tick && (cnt == S_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      samp     <= '1;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      samp     <= samp_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    samp_n     = samp;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    complete   = 1'b0;

    if (state != IDLE && state != BREAK && b_tick) begin
      cnt_n = (cnt == S_END) ? '0 : cnt + 1'b1;
      if (cnt == S_LO)  samp_n[0] = rxs;
      if (cnt == S_MID) samp_n[1] = rxs;
    end

    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n    = START;
          cnt_n      = '0;
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          shreg_n    = '0;
          perr_n     = 1'b0;
          ferr_n     = 1'b0;
        end
      end
      START: begin
        if (decide && maj) state_n = IDLE;
        else if (bit_end)  state_n = DATA;
      end
      DATA: begin
        if (decide) begin
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (bit_idx == 4'(i)) shreg_n[i] = maj;
          end
        end
        if (bit_end) begin
          if (bit_idx == LAST_BIT) state_n = (PARITY_EN != 0) ? PARITY : STOP;
          else                     bit_idx_n = bit_idx + 4'd1;
        end
      end
      PARITY: begin
        if (decide)  perr_n  = (maj != ((^shreg) ^ PAR_ODD));
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        // Completion happens at the last stop bit's decision point so the next start edge is not missed.
        if (decide) begin
          if (!maj) ferr_n = 1'b1;
          if (stop_idx == LAST_STOP) begin
            complete = 1'b1;
            state_n  = (ferr || !maj) ? BREAK : IDLE;
          end
        end else if (bit_end) begin
          stop_idx_n = 1'b1;
        end
      end
      BREAK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr;
          frame_err  <= ferr_n;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the UART path. Consumes the shared oversampling tick `b_tick` from the baud generator.
- Configurable data width, optional parity, 1 or 2 stop bits, configurable oversampling.
- Glitch-filtered start detection and 3-sample majority voting.
- Delivers frames through a 1-deep valid/ready holding register with per-frame error flags and overrun reporting.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, b_tick pulses per bit period (even, 8..32)
PARITY_EN, 0, 1 = parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
b_tick  in  1  one-clk oversampling strobe, OVERSAMPLE per bit
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received data, valid while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the held frame (0 when PARITY_EN=0)
frame_err  out  1  a stop-bit sample was 0 for the held frame
overrun  out  1  one-clk pulse: a frame completed while the holding register was full and not draining; that frame was discarded

Behaviour:
- Reset: when rst_n=0 at a clk edge, the block returns to IDLE and clears all counters. Outputs after reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0. The rx synchronizer flops reset to 1. Reset mid-frame abandons the frame with no output.
- Input: rx passes through a 2-FF synchronizer (rxs). All decisions use rxs.
- Tick counter: cnt runs 0..OVERSAMPLE-1 within each bit period and advances only on b_tick. Let M = OVERSAMPLE/2.
- Sampling: samples are taken at cnt = M-1, M, M+1. The bit value is the majority of the three, decided on the b_tick where cnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rxs=0 -> START, cnt=0. No b_tick is required to leave IDLE.
  - START: if the majority is 1, it is a false start: go to IDLE with no outputs. If the majority is 0, continue the bit and enter DATA at cnt wrap.
  - DATA: shift the bit into bit position bit_idx, LSB first. After DATA_BITS bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: compare the sample against the XOR of the data bits, XORed with PARITY_ODD. On mismatch, perr=1.
  - STOP: a 0 sample sets ferr=1. Frame completion occurs at the decision point (cnt=M+1) of the last stop bit, not at the end of the bit, to allow resync on back-to-back frames.
    - ferr=0: next state is IDLE.
    - ferr=1: next state is BREAK.
    - With STOP_BITS=2, a frame error on the first stop bit still samples the second stop bit.
  - BREAK: wait until rxs=1, then go to IDLE. No start detection occurs while in BREAK.
- Completion, on the cycle after the completing b_tick edge:
  - If rx_valid=0, or rx_ready=1 in the completing cycle: load rx_data, parity_err, frame_err and set rx_valid=1.
  - Otherwise: discard the frame and pulse overrun=1 for exactly one clk. The held data and flags are unchanged.
- Handshake:
  - rx_valid && rx_ready with no simultaneous completion: rx_valid=0 next cycle. parity_err and frame_err clear with it.
  - Simultaneous accept and completion: the new frame loads, rx_valid stays 1, no overrun.
  - rx_data is stable while rx_valid=1 && rx_ready=0.
- Errors do not suppress delivery. A frame with a frame or parity error is still presented with its flags set.
- With DATA_BITS=9, PARITY_EN=1 and STOP_BITS=2, the frame is 13 bits. Counters are sized for this maximum.

Test Plan:
- Normal frame: defaults, rx_ready=1, send 0x55 then 0xA3 back-to-back with 1 stop bit -> two rx_valid pulses, rx_data=0x55 then 0xA3, all error flags 0.
- Glitch and majority:
  - rx low for 4 b_ticks then high -> no rx_valid, FSM back in IDLE.
  - 1-tick low glitch at cnt=M of data bit 3 of 0xFF -> rx_data=0xFF.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- Frame error and break: stop bit driven 0, rx held low 40 b_ticks, then a valid 0x3C frame -> first delivery has frame_err=1. No spurious frames during the low period. Next delivery is 0x3C with frame_err=0.
- Overrun: rx_ready=0, send 0x12 then 0x34 -> rx_data stays 0x12, rx_valid=1, one overrun pulse. Raise rx_ready for 1 clk -> rx_valid=0.
- Reset and config sweep:
  - Assert rst_n=0 during bit 4 of a frame -> all outputs 0. The next full frame 0x5A is received correctly.
  - Repeat the normal-frame test with DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=8.
